dvp_capture: RTL
================

Name: dvp_capture

Overview:
- Receive end of the camera video path. Consumes the OV7670-style DVP stream: VSYNC, HREF and an 8-bit byte bus, all synchronous to PCLK.
- Assembles two-byte RGB565 pixels and emits frame-buffer write strobes with a linear address plus x/y coordinates.
- Its output feeds the 76800-entry frame buffer that the VGA timing generator reads out.
- clk_i is the camera PCLK; the whole block runs in that single domain.

Parameters:
ACTIVE_COLUMNS, 320, pixels per line (each pixel is 2 bytes on the bus)
ACTIVE_ROWS, 240, lines per frame
ADDR_W, $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS) = 17, frame-buffer address width

Ports:
clk_i  in  1  camera PCLK, rising-edge
reset_n_i  in  1  asynchronous, active-low reset
capture_en_i  in  1  arm capture; sampled only at frame start
vsync_i  in  1  camera VSYNC, high during the frame-start pulse
href_i  in  1  camera HREF, high while the line's bytes are valid
data_i  in  8  camera byte bus
pixel_o  out  16  RGB565 pixel, {first byte, second byte}
wr_en_o  out  1  one-cycle write strobe for pixel_o/addr_o
addr_o  out  ADDR_W  linear write address, y*ACTIVE_COLUMNS+x
x_o  out  $clog2(ACTIVE_COLUMNS)  column of current write
y_o  out  $clog2(ACTIVE_ROWS)  row of current write
frame_done_o  out  1  one-cycle pulse at the end of a captured frame
line_err_o  out  1  sticky; set on a malformed line or frame; cleared at the next armed frame start
busy_o  out  1  high in the ACTIVE state

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; byte phase 0; all counters 0.
- Input stage:
  - vsync_i, href_i and data_i are registered once (stage S1).
  - Edges are detected by comparing S1 against a second register (S2).
- FSM states:
  - IDLE: wait for a vsync rising edge. On that edge, if capture_en_i=1, go to SYNC and clear line_err_o and all counters. Otherwise stay in IDLE.
  - SYNC: wait for the vsync falling edge, then go to ACTIVE.
  - ACTIVE:
    - Capture bytes whenever href(S1)=1.
    - On a vsync rising edge: pulse frame_done_o, then re-evaluate capture_en_i exactly as IDLE does. If it is 1, go to SYNC and clear counters; otherwise go to IDLE.
    - Deasserting capture_en_i mid-frame has no effect until this frame boundary.
- Byte assembly (ACTIVE, href=1):
  - Phase 0: latch the byte as the high byte.
  - Phase 1: form the pixel {hi, byte}.
  - Phase toggles on every href-high cycle.
  - Latency: wr_en_o, pixel_o, addr_o, x_o and y_o are registered and assert 2 clk_i edges after the edge at which the low byte is present on the pins.
  - wr_en_o is high for exactly 1 cycle per pixel.
- Counters:
  - x increments after each write.
  - On the href falling edge: x resets to 0, y increments, phase resets to 0.
  - addr increments after each write. It is not recomputed from x/y.
- Boundary conditions:
  - Href falling with x != ACTIVE_COLUMNS, or with phase=1 (odd byte count): set line_err_o. The partial byte is discarded. y still advances.
  - Write attempt with x = ACTIVE_COLUMNS (line too long): suppress the write and set line_err_o.
  - Write attempt with y = ACTIVE_ROWS (too many lines): suppress the write and set line_err_o. addr never exceeds ACTIVE_COLUMNS*ACTIVE_ROWS-1.
  - Vsync rising edge in ACTIVE with y != ACTIVE_ROWS: frame_done_o still pulses and line_err_o is set.
  - Href high during SYNC or IDLE: ignored.
  - Vsync rising edge coinciding with href=1: the vsync edge wins; that byte is dropped.
  - reset_n_i asserted mid-frame: immediate return to reset values. A new capture requires a fresh vsync rising edge.

Test Plan:
- Reset, capture_en_i=1, one full 320x240 frame of incrementing bytes -> 76800 wr_en_o pulses. First pixel 0x0001 at addr 0; last at addr 76799, x=319, y=239. One frame_done_o pulse; line_err_o=0.
- capture_en_i=0 at the vsync edge, then a full frame -> zero writes, busy_o=0, no frame_done_o. Raise enable and send the next frame -> captured normally.
- Line 5 carries 638 bytes -> line_err_o=1 after href falls. Line 6 first write at addr 1920 (y=6, x=0). Next frame start clears line_err_o.
- Line carries 642 bytes -> the 321st pixel is suppressed (no write), line_err_o=1, addr continues at the next line base.
- Deassert capture_en_i at row 100 -> frame completes to addr 76799 with frame_done_o, then IDLE and no further writes.
- Assert reset_n_i low at row 50, x=10 -> all outputs 0 asynchronously. After release, href activity before a vsync rising edge produces no writes.

Source files
------------

// File: rtl/dvp_capture.sv
// dvp_capture: receive side of the camera video path.
// Takes an OV7670-style DVP byte stream (VSYNC/HREF/8-bit bus, all on PCLK),
// pairs bytes into RGB565 pixels and emits frame-buffer write strobes with a
// linear address and x/y coordinates. Malformed lines/frames raise a sticky
// error flag that clears at the next armed frame start.
module dvp_capture #(
   parameter int DATA_W         = 8,
   parameter int ACTIVE_COLUMNS = 320,
   parameter int ACTIVE_ROWS    = 240,
   parameter int ADDR_W         = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS)
) (
   input  logic                              clk_i,
   input  logic                              reset_n_i,
   input  logic                              capture_en_i,
   input  logic                              vsync_i,
   input  logic                              href_i,
   input  logic [DATA_W-1:0]                 data_i,
   output logic [2*DATA_W-1:0]               pixel_o,
   output logic                              wr_en_o,
   output logic [ADDR_W-1:0]                 addr_o,
   output logic [$clog2(ACTIVE_COLUMNS)-1:0] x_o,
   output logic [$clog2(ACTIVE_ROWS)-1:0]    y_o,
   output logic                              frame_done_o,
   output logic                              line_err_o,
   output logic                              busy_o
);
   localparam int X_W  = $clog2(ACTIVE_COLUMNS);
   localparam int Y_W  = $clog2(ACTIVE_ROWS);
   // Counters are wide enough to hold the "line full" / "frame full" values
   localparam int XC_W = $clog2(ACTIVE_COLUMNS + 1);
   localparam int YC_W = $clog2(ACTIVE_ROWS + 1);
   localparam int AC_W = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS + 1);
   localparam logic [XC_W-1:0] COLS_C = XC_W'(ACTIVE_COLUMNS);
   localparam logic [YC_W-1:0] ROWS_C = YC_W'(ACTIVE_ROWS);

   typedef enum logic [1:0] {IDLE, SYNC, ACTIVE} state_t;

   state_t              state_q;
   logic                vsync_p1, href_p1, vsync_p2, href_p2;
   logic [DATA_W-1:0]   data_p1;
   logic [DATA_W-1:0]   hi_q;
   logic                phase_q;
   logic [XC_W-1:0]     x_q;
   logic [YC_W-1:0]     y_q;
   logic [AC_W-1:0]     addr_q;
   logic                vld_p2;
   logic [2*DATA_W-1:0] pix_p2;
   logic [ADDR_W-1:0]   waddr_p2;
   logic [X_W-1:0]      wx_p2;
   logic [Y_W-1:0]      wy_p2;

   logic vs_rise, vs_fall, href_fall, byte_ok, hi_load, write_go;

   assign vs_rise   = vsync_p1 & ~vsync_p2;
   assign vs_fall   = ~vsync_p1 & vsync_p2;
   assign href_fall = href_p2 & ~href_p1;
   // A vsync edge wins over a coincident href byte, which is then dropped
   assign byte_ok   = (state_q == ACTIVE) && !vs_rise && href_p1;
   assign hi_load   = byte_ok && !phase_q;
   assign write_go  = byte_ok && phase_q && (x_q != COLS_C) && (y_q != ROWS_C);

   // Stage S1/S2: register camera control lines twice for edge detection
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         vsync_p1 <= 1'b0;
         href_p1  <= 1'b0;
         vsync_p2 <= 1'b0;
         href_p2  <= 1'b0;
      end else begin
         vsync_p1 <= vsync_i;
         href_p1  <= href_i;
         vsync_p2 <= vsync_p1;
         href_p2  <= href_p1;
      end
   end

   // Byte bus capture, high-byte hold and pixel assembly (pure data, no reset)
   always_ff @(posedge clk_i) begin
      data_p1 <= data_i;
      if (hi_load)  hi_q   <= data_p1;
      if (write_go) pix_p2 <= {hi_q, data_p1};
   end

   // Frame/line sequencing, counters, error flag and write staging
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q      <= IDLE;
         phase_q      <= 1'b0;
         x_q          <= '0;
         y_q          <= '0;
         addr_q       <= '0;
         vld_p2       <= 1'b0;
         waddr_p2     <= '0;
         wx_p2        <= '0;
         wy_p2        <= '0;
         frame_done_o <= 1'b0;
         line_err_o   <= 1'b0;
         busy_o       <= 1'b0;
      end else begin
         vld_p2       <= write_go;
         frame_done_o <= 1'b0;
         if (write_go) begin
            waddr_p2 <= ADDR_W'(addr_q);
            wx_p2    <= X_W'(x_q);
            wy_p2    <= Y_W'(y_q);
         end
         case (state_q)
            IDLE: begin
               if (vs_rise && capture_en_i) begin
                  state_q    <= SYNC;
                  line_err_o <= 1'b0;
                  phase_q    <= 1'b0;
                  x_q        <= '0;
                  y_q        <= '0;
                  addr_q     <= '0;
               end
            end
            SYNC: begin
               if (vs_fall) begin
                  state_q <= ACTIVE;
                  busy_o  <= 1'b1;
               end
            end
            ACTIVE: begin
               if (vs_rise) begin
                  frame_done_o <= 1'b1;
                  busy_o       <= 1'b0;
                  if (capture_en_i) begin
                     // Re-armed: a short frame still reports, otherwise clear
                     state_q    <= SYNC;
                     line_err_o <= (y_q != ROWS_C);
                     phase_q    <= 1'b0;
                     x_q        <= '0;
                     y_q        <= '0;
                     addr_q     <= '0;
                  end else begin
                     state_q <= IDLE;
                     if (y_q != ROWS_C) line_err_o <= 1'b1;
                  end
               end else if (href_p1) begin
                  phase_q <= ~phase_q;
                  if (phase_q) begin
                     if (write_go) begin
                        x_q    <= x_q + XC_W'(1);
                        addr_q <= addr_q + AC_W'(1);
                     end else begin
                        line_err_o <= 1'b1;
                     end
                  end
               end else if (href_fall) begin
                  if ((x_q != COLS_C) || phase_q) line_err_o <= 1'b1;
                  phase_q <= 1'b0;
                  x_q     <= '0;
                  // Skip the unwritten tail of a short line so addr stays at y*COLS+x
                  if (y_q != ROWS_C) begin
                     y_q    <= y_q + YC_W'(1);
                     addr_q <= addr_q + AC_W'(COLS_C - x_q);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Output stage: registered write strobe and its payload
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wr_en_o <= 1'b0;
         pixel_o <= '0;
         addr_o  <= '0;
         x_o     <= '0;
         y_o     <= '0;
      end else begin
         wr_en_o <= vld_p2;
         if (vld_p2) begin
            pixel_o <= pix_p2;
            addr_o  <= waddr_p2;
            x_o     <= wx_p2;
            y_o     <= wy_p2;
         end
      end
   end

endmodule
